case_convert_stream: RTL
========================

# case_convert_stream

Streaming ASCII case converter: the multi-lane, multi-mode successor to the single-byte combinational upper-case converter. Accepts LANES bytes per beat over a valid/ready handshake and applies pass-through, upper, lower or title-case conversion. Title-case word state carries across beats within a packet. Output is registered, with full throughput, and a saturating counter reports how many bytes were modified. Sits in the text datapath between the byte source and downstream formatters.

## Interface
- LANES, 4, bytes per beat; lane k = data[8k+7:8k], lane 0 is the earliest character
- CNT_W, 16, width of the modified-byte counter
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- mode  in  2  sampled with each accepted beat: 00 pass, 01 upper, 10 lower, 11 title
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid && s_ready
- s_data  in  8*LANES  input bytes
- s_keep  in  LANES  per-lane enable; disabled lanes are forwarded unmodified
- s_last  in  1  beat ends packet
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accept
- m_data  out  8*LANES  converted bytes
- m_keep  out  LANES  s_keep, registered
- m_last  out  1  s_last, registered
- clr  in  1  synchronous clear of conv_count
- conv_count  out  CNT_W  saturating count of modified bytes

## Operation
- Letter classification: upper is 0x41–0x5A; lower is 0x61–0x7A; every other byte, including 0x80–0xFF, is a non-letter and is never modified.
- Upper mode: lower letters are converted by subtracting 0x20. Lower mode: upper letters are converted by adding 0x20. Pass mode: output equals input.
- Title mode: a letter whose predecessor state is "not in word" becomes upper case. A letter whose predecessor state is "in word" becomes lower case.
- Predecessor state is taken from the nearest lower-index enabled lane in the same beat. If there is none, it comes from the carried flag word_f.
- word_f update on accept: set to the letter-ness of the highest enabled lane. If the beat has no enabled lanes, word_f is unchanged. If s_last=1, word_f is cleared to 0 instead.
- word_f is tracked in every mode, so a switch into title mode mid-packet uses the true context.
- Disabled lanes pass through unchanged, do not count as modified, and are invisible to word tracking.
- conv_count adds the number of enabled lanes whose output differs from input, on each accepted beat. It saturates at 2^CNT_W−1.
- clr takes precedence over a same-cycle add: the result is 0 and that beat's modifications are dropped.

## Timing
- Single output register stage. Latency is 1 cycle from input accept to m_valid.
- s_ready = !rst && (!m_valid || m_ready). This gives one beat per cycle under continuous m_ready, with no bubbles.
- On accept, m_data, m_keep and m_last load and m_valid=1. Otherwise, if m_ready=1, m_valid clears.
- While m_valid && !m_ready, all m_* outputs hold stable.
- conv_count and word_f update on the accept edge. The new count is visible the following cycle.
- Reset values: m_valid=0, m_data=0, m_keep=0, m_last=0, conv_count=0, word_f=0. s_ready=0 while rst=1.
- Reset mid-packet discards any held output beat. The next packet starts with word_f=0.
- Simultaneous accept of a new beat and drain of the held beat (m_valid && m_ready && s_valid) is legal: the register reloads with no gap.

## Test plan
- Upper mode, keep=0xF, beats {0x61,0x7A,0x7B,0x40} then {0xEB,0x41,0x60,0x20} -> {0x41,0x5A,0x7B,0x40}, {0xEB,0x41,0x60,0x20}; conv_count=2.
- Title mode, packet "hELL","o wO","rld!" (last on third beat) -> "Hell","o Wo","rld!"; conv_count=6. This checks word state carried across the beat boundary.
- Title mode, keep=0b1011 on "ab?c" (lane 2 disabled) -> "Ab?c"; lane 2 is forwarded raw, and lane 3 sees lane 1 as its predecessor so stays lower. A following packet starting "x" -> "X" after the s_last clear.
- Backpressure: 3 beats are offered with m_ready=0 for 4 cycles. Required: one beat held stable, s_ready=0, no loss or duplication. After m_ready=1 for 3 cycles, all beats emerge in order.
- Counter: CNT_W=3, lower mode, beats "ABCD","EFGH" -> count saturates at 7. clr asserted together with an accepted "IJKL" beat -> count reads 0 next cycle.
- rst pulsed while m_valid=1 and word_f=1 -> next cycle m_valid=0, conv_count=0. A title beat "abc " afterwards -> "Abc ".

Source files
------------

// File: rtl/case_convert_stream.sv
// Streaming ASCII case converter: LANES bytes per beat, pass/upper/lower/title modes,
// one registered output stage and a saturating count of modified bytes.
module case_convert_stream #(
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           mode,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [8*LANES-1:0]   s_data,
    input  logic [LANES-1:0]     s_keep,
    input  logic                 s_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [8*LANES-1:0]   m_data,
    output logic [LANES-1:0]     m_keep,
    output logic                 m_last,
    input  logic                 clr,
    output logic [CNT_W-1:0]     conv_count
);
    localparam logic [1:0] MODE_UPPER = 2'b01;
    localparam logic [1:0] MODE_LOWER = 2'b10;
    localparam logic [1:0] MODE_TITLE = 2'b11;
    localparam int NM_W = $clog2(LANES + 1);

    logic                 m_valid_q, m_valid_d;
    logic [8*LANES-1:0]   m_data_q, m_data_d;
    logic [LANES-1:0]     m_keep_q, m_keep_d;
    logic                 m_last_q, m_last_d;
    logic                 word_q, word_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 accept;
    logic [8*LANES-1:0]   conv;
    logic [NM_W-1:0]      n_mod;
    logic                 ctx;
    logic [7:0]           lane_in, lane_out;
    logic                 is_up, is_lo;
    logic [CNT_W:0]       cnt_sum;

    assign s_ready = !rst && (!m_valid_q || m_ready);
    assign accept  = s_valid && s_ready;

    // ctx walks up the enabled lanes, so each lane sees its nearest enabled predecessor
    always_comb begin
        conv     = s_data;
        n_mod    = '0;
        ctx      = word_q;
        lane_in  = '0;
        lane_out = '0;
        is_up    = 1'b0;
        is_lo    = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            lane_in  = s_data[8*k +: 8];
            is_up    = (lane_in >= 8'h41) && (lane_in <= 8'h5A);
            is_lo    = (lane_in >= 8'h61) && (lane_in <= 8'h7A);
            lane_out = lane_in;
            if (s_keep[k]) begin
                case (mode)
                    MODE_UPPER: if (is_lo) lane_out = lane_in - 8'h20;
                    MODE_LOWER: if (is_up) lane_out = lane_in + 8'h20;
                    MODE_TITLE: begin
                        if (is_lo && !ctx)
                            lane_out = lane_in - 8'h20;
                        else if (is_up && ctx)
                            lane_out = lane_in + 8'h20;
                    end
                    default: lane_out = lane_in;
                endcase
                if (lane_out != lane_in)
                    n_mod = n_mod + 1'b1;
                ctx = is_up || is_lo;
            end
            conv[8*k +: 8] = lane_out;
        end
    end

    assign cnt_sum = {1'b0, cnt_q} + {{(CNT_W + 1 - NM_W){1'b0}}, n_mod};

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (accept)
            cnt_d = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end

    assign word_d = accept ? (s_last ? 1'b0 : ctx) : word_q;

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_keep_d  = m_keep_q;
        m_last_d  = m_last_q;
        if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = conv;
            m_keep_d  = s_keep;
            m_last_d  = s_last;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_keep_q  <= '0;
            m_last_q  <= 1'b0;
            word_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_keep_q  <= m_keep_d;
            m_last_q  <= m_last_d;
            word_q    <= word_d;
            cnt_q     <= cnt_d;
        end
    end

    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_keep     = m_keep_q;
    assign m_last     = m_last_q;
    assign conv_count = cnt_q;
endmodule
